// File: rtl/crc_out_serializer_pkg.sv
// rtl/crc_out_serializer_pkg.sv - shared sizing defaults and FSM state type for the CRC output serializer
// Defaults switch to 64-bit sizing when CRC64 is defined.
package crc_out_serializer_pkg;

`ifdef CRC64
  localparam int DEF_MAX_BITS       = 64;
  localparam int DEF_MAX_BYTES      = 8;
  localparam int DEF_MAX_BYTE_WIDTH = 3;
`else
  localparam int DEF_MAX_BITS       = 32;
  localparam int DEF_MAX_BYTES      = 4;
  localparam int DEF_MAX_BYTE_WIDTH = 2;
`endif

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/crc_out_serializer.sv
// rtl/crc_out_serializer.sv - emits a captured CRC word MS valid byte first over a byte stream
// Optional CRC_OUT_XOR_EN adds an xorout port applied at capture time.
module crc_out_serializer
  import crc_out_serializer_pkg::*;
#(
  parameter int MAX_BITS       = DEF_MAX_BITS,
  parameter int MAX_BYTES      = DEF_MAX_BYTES,
  parameter int MAX_BYTE_WIDTH = DEF_MAX_BYTE_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [MAX_BITS-1:0]       load_value,
  input  logic [MAX_BYTE_WIDTH-1:0] load_bytewidth,
`ifdef CRC_OUT_XOR_EN
  input  logic [MAX_BITS-1:0]       xorout,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_byte,
  output logic                      out_last,
  output logic                      busy
);

  state_t                    state;
  logic [MAX_BITS-1:0]       shreg;
  logic [MAX_BYTE_WIDTH-1:0] cnt;

  logic [MAX_BYTE_WIDTH-1:0] bw_clamped;
  logic [MAX_BITS-1:0]       keep_mask;
  logic [MAX_BITS-1:0]       capture_word;

  // Bytes above the valid width are zeroed so they can never reach the output.
  always_comb begin
    bw_clamped = load_bytewidth;
    if (int'(load_bytewidth) >= MAX_BYTES)
      bw_clamped = MAX_BYTE_WIDTH'(MAX_BYTES - 1);
    keep_mask = '0;
    for (int i = 0; i < MAX_BYTES; i++)
      if (i <= int'(bw_clamped))
        keep_mask[i*8 +: 8] = 8'hFF;
`ifdef CRC_OUT_XOR_EN
    capture_word = (load_value ^ xorout) & keep_mask;
`else
    capture_word = load_value & keep_mask;
`endif
  end

  assign load_ready = (state == ST_IDLE) && !reset;

  // out_byte is preloaded with the next byte so all handshake outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_valid) begin
            state     <= ST_SHIFT;
            shreg     <= capture_word;
            cnt       <= bw_clamped;
            out_valid <= 1'b1;
            out_byte  <= capture_word[int'(bw_clamped)*8 +: 8];
            out_last  <= (bw_clamped == '0);
            busy      <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (out_ready) begin
            if (cnt != '0) begin
              cnt      <= cnt - MAX_BYTE_WIDTH'(1);
              out_byte <= shreg[(int'(cnt) - 1)*8 +: 8];
              out_last <= (cnt == MAX_BYTE_WIDTH'(1));
            end else begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              out_byte  <= 8'h00;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_out_serializer.sv
// tb/tb_crc_out_serializer.sv - directed vector bench for crc_out_serializer
// Expectations follow the CRC_OUT_XOR_EN setting of the build.
module tb_crc_out_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_value;
  logic [1:0]  load_bytewidth;
`ifdef CRC_OUT_XOR_EN
  logic [31:0] xorout;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  crc_out_serializer dut (
    .clk            (clk),
    .reset          (reset),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_value     (load_value),
    .load_bytewidth (load_bytewidth),
`ifdef CRC_OUT_XOR_EN
    .xorout         (xorout),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_byte       (out_byte),
    .out_last       (out_last),
    .busy           (busy)
  );

  typedef struct {
    logic [31:0] value;
    logic [31:0] xr;
    logic [1:0]  bw;
    int          nbytes;
    logic [31:0] exp_bytes;  // first emitted byte in [31:24]
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [31:0] v, input logic [31:0] xr, input logic [1:0] bw);
    load_valid     = 1'b1;
    load_value     = v;
    load_bytewidth = bw;
`ifdef CRC_OUT_XOR_EN
    xorout         = xr;
`else
    if (xr != 32'h0) load_valid = 1'b1;
`endif
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    check({tag, "_out_byte"}, 32'(out_byte), 32'h0);
  endtask

  task automatic check_byte(input string tag, input logic [7:0] b, input logic last);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_byte"}, 32'(out_byte), 32'(b));
    check({tag, "_last"}, 32'(out_last), 32'(last));
    check({tag, "_load_ready"}, 32'(load_ready), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h11223344, 32'h0, 2'd3, 4, 32'h11223344};
    vecs[1] = '{32'hDEADBEEF, 32'h0, 2'd0, 1, 32'hEF000000};
    vecs[2] = '{32'h00ABCDEF, 32'h0, 2'd2, 3, 32'hABCDEF00};
    vecs[3] = '{32'h12345678, 32'h0, 2'd1, 2, 32'h56780000};
`ifdef CRC_OUT_XOR_EN
    vecs[4] = '{32'hCBF43926, 32'hFFFFFFFF, 2'd3, 4, 32'h340BC6D9};
    vecs[5] = '{32'h1234ABCD, 32'h0000FFFF, 2'd1, 2, 32'h54320000};
`else
    vecs[4] = '{32'hCBF43926, 32'hFFFFFFFF, 2'd3, 4, 32'hCBF43926};
    vecs[5] = '{32'h1234ABCD, 32'h0000FFFF, 2'd1, 2, 32'hABCD0000};
`endif

    reset          = 1'b1;
    load_valid     = 1'b0;
    load_value     = '0;
    load_bytewidth = '0;
    out_ready      = 1'b0;
`ifdef CRC_OUT_XOR_EN
    xorout         = '0;
`endif
    step();
    step();
    check("reset_load_ready", 32'(load_ready), 32'd0);
    reset = 1'b0;
    #1;
    check_idle("reset");
    check("reset_out_last", 32'(out_last), 32'd0);

    // Table vectors, consumer always ready.
    for (int v = 0; v < 6; v++) begin
      out_ready = 1'b1;
      drive_load(vecs[v].value, vecs[v].xr, vecs[v].bw);
      step();
      load_valid = 1'b0;
      for (int k = 0; k < vecs[v].nbytes; k++) begin
        check_byte($sformatf("vec%0d_b%0d", v, k), vecs[v].exp_bytes[31-8*k -: 8],
                   k == vecs[v].nbytes - 1);
        step();
      end
      check_idle($sformatf("vec%0d_end", v));
    end

    // Backpressure: consumer stalls for five cycles.
    out_ready = 1'b0;
    drive_load(32'h0000A5C3, 32'h0, 2'd1);
    step();
    load_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_byte($sformatf("stall%0d", k), 8'hA5, 1'b0);
      step();
    end
    out_ready = 1'b1;
    check_byte("bp_b0", 8'hA5, 1'b0);
    step();
    check_byte("bp_b1", 8'hC3, 1'b1);
    step();
    check_idle("bp_end");

    // Reset after the second byte has been taken.
    drive_load(32'h11223344, 32'h0, 2'd3);
    step();
    load_valid = 1'b0;
    check_byte("rst_b0", 8'h11, 1'b0);
    step();
    check_byte("rst_b1", 8'h22, 1'b0);
    step();
    reset = 1'b1;
    #1;
    check("rst_load_ready_low", 32'(load_ready), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check_idle("rst_after");
    check("rst_out_last", 32'(out_last), 32'd0);
    drive_load(32'h0000007E, 32'h0, 2'd0);
    step();
    load_valid = 1'b0;
    check_byte("rst_new", 8'h7E, 1'b1);
    step();
    check_idle("rst_new_end");

    // Load held during SHIFT is not taken until the next IDLE cycle.
    drive_load(32'h0000AABB, 32'h0, 2'd1);
    step();
    drive_load(32'h00000077, 32'h0, 2'd0);
    check_byte("lwb_b0", 8'hAA, 1'b0);
    step();
    check_byte("lwb_b1", 8'hBB, 1'b1);
    step();
    check("lwb_gap_valid", 32'(out_valid), 32'd0);
    check("lwb_gap_ready", 32'(load_ready), 32'd1);
    step();
    load_valid = 1'b0;
    check_byte("lwb_w2", 8'h77, 1'b1);
    step();
    check_idle("lwb_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
